// File: rtl/nes_trace_reader.sv
// CPU bus trace FIFO drained byte-wise by the host slave port.
// Optional start trigger on a bus address is compiled in with NES_TRACE_TRIGGER_EN.
module nes_trace_reader #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_ready,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  input  logic        sync,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        irq_nonempty
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0] mem [1 << DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [1:0]            byte_ptr_q, byte_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  armed_q, armed_d;
  logic [7:0]            readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic                  pending_q, pending_d;
  logic [15:0]           trig_addr_q, trig_addr_d;

  logic        host_rd, host_wr, ctrl_wr, data_rd;
  logic        empty, full;
  logic        trig_hit, capture, push, pop, mem_we;
  logic [31:0] entry, head_entry;
  logic [7:0]  head_byte, status;
  logic        unused_bits;

  // Write wins over read when both strobes are presented together.
  assign host_wr = chipselect & write;
  assign host_rd = chipselect & read & ~write;
  assign ctrl_wr = host_wr & (address == 3'd0);
  assign data_rd = host_rd & (address == 3'd3);

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_COUNT);
  assign entry      = {sync, cpu_write, 6'b0, cpu_addr, cpu_write ? cpu_d_out : cpu_d_in};
  assign head_entry = mem[rd_ptr_q];
  assign status     = {4'b0, pending_q, overflow_q, full, empty};

  always_comb begin
    head_byte = 8'h00;
    case (byte_ptr_q)
      2'd0: head_byte = head_entry[15:8];
      2'd1: head_byte = head_entry[23:16];
      2'd2: head_byte = head_entry[7:0];
      default: head_byte = head_entry[31:24];
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    byte_ptr_d  = byte_ptr_q;
    overflow_d  = overflow_q;
    armed_d     = armed_q;
    readdata_d  = readdata_q;
    pending_d   = pending_q;
    trig_addr_d = trig_addr_q;
    trig_hit    = 1'b0;
    capture     = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    mem_we      = 1'b0;

`ifdef NES_TRACE_TRIGGER_EN
    trig_hit = pending_q & cpu_ready & (cpu_addr == trig_addr_q);
    if (trig_hit) begin
      armed_d   = 1'b1;
      pending_d = 1'b0;
    end
`endif

    capture = cpu_ready & (armed_q | trig_hit);
    pop     = data_rd & ~empty & (byte_ptr_q == 2'd3);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = capture & (~full | pop);

    if (data_rd && !empty)
      byte_ptr_d = byte_ptr_q + 2'd1;
    if (push)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
    if (capture && !push)
      overflow_d = 1'b1;

    if (host_rd) begin
      case (address)
        3'd0:    readdata_d = status;
        3'd1:    readdata_d = 8'(count_q);
        3'd2:    readdata_d = 8'(count_q >> 8);
        3'd3:    readdata_d = empty ? 8'h00 : head_byte;
        default: readdata_d = 8'h00;
      endcase
    end

`ifdef NES_TRACE_TRIGGER_EN
    if (host_wr && address == 3'd4)
      trig_addr_d[7:0] = writedata;
    if (host_wr && address == 3'd5)
      trig_addr_d[15:8] = writedata;
    if (ctrl_wr && writedata[2])
      pending_d = 1'b1;
`endif

    if (ctrl_wr) begin
      armed_d = writedata[1];
      if (writedata[0]) begin
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        count_d    = '0;
        byte_ptr_d = 2'd0;
        overflow_d = 1'b0;
        push       = 1'b0;
      end
    end

    mem_we = push;
    irq_d  = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      byte_ptr_q  <= 2'd0;
      overflow_q  <= 1'b0;
      armed_q     <= 1'b0;
      readdata_q  <= 8'h00;
      irq_q       <= 1'b0;
      pending_q   <= 1'b0;
      trig_addr_q <= 16'h0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      byte_ptr_q  <= byte_ptr_d;
      overflow_q  <= overflow_d;
      armed_q     <= armed_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      pending_q   <= pending_d;
      trig_addr_q <= trig_addr_d;
    end
  end

`ifdef NES_TRACE_TRIGGER_EN
  assign unused_bits = ^writedata[7:3];
`else
  assign unused_bits = ^{writedata[7:2], trig_hit};
`endif

  assign readdata     = readdata_q;
  assign irq_nonempty = irq_q;

endmodule

// File: tb/tb_nes_trace_reader.sv
// Directed bench for nes_trace_reader: register map, capture format, full/overflow,
// pop-while-full, clear precedence and reset mid-drain.
module tb_nes_trace_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_in, cpu_d_out;
  logic        cpu_write, sync;
  logic        chipselect, read, write;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        irq_nonempty;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nes_trace_reader #(.DEPTH_LOG2(8)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .cpu_write(cpu_write), .sync(sync),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .irq_nonempty(irq_nonempty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stimulus pattern for capture index i: reads on even pairs, writes when bit1 set.
  function automatic logic [31:0] exp_entry(input int i);
    logic [15:0] a;
    logic [7:0]  din, dout;
    logic        w, s;
    a    = 16'h4000 + 16'(i);
    din  = 8'(i) ^ 8'h5A;
    dout = ~8'(i);
    w    = (i & 2) != 0;
    s    = (i & 1) != 0;
    return {s, w, 6'b0, a, w ? dout : din};
  endfunction

  task automatic drive_cap(input int i);
    cpu_ready = 1'b1;
    cpu_addr  = 16'h4000 + 16'(i);
    cpu_d_in  = 8'(i) ^ 8'h5A;
    cpu_d_out = ~8'(i);
    cpu_write = (i & 2) != 0;
    sync      = (i & 1) != 0;
  endtask

  task automatic capture_run(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive_cap(first + k);
    end
    @(negedge clk);
    cpu_ready = 1'b0;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic read_entry(output logic [31:0] e);
    logic [7:0] b0, b1, b2, b3;
    host_read(3'd3, b0);
    host_read(3'd3, b1);
    host_read(3'd3, b2);
    host_read(3'd3, b3);
    e = {b3, b1, b0, b2};
  endtask

  initial begin
    logic [7:0]  d;
    logic [31:0] e;

    reset_n = 1'b0; cpu_ready = 1'b0; cpu_addr = '0; cpu_d_in = '0; cpu_d_out = '0;
    cpu_write = 1'b0; sync = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("rst_readdata", 32'(readdata), 32'h00);
    check("rst_irq", 32'(irq_nonempty), 32'h0);
    host_read(3'd0, d); check("rst_status", 32'(d), 32'h01);
    host_read(3'd1, d); check("rst_count_lo", 32'(d), 32'h00);
    host_read(3'd2, d); check("rst_count_hi", 32'(d), 32'h00);
    host_read(3'd3, d); check("rst_data_empty", 32'(d), 32'h00);

    // Write with chipselect low must not arm; unarmed bus cycles are not captured
    @(negedge clk);
    write = 1'b1; address = 3'd0; writedata = 8'h02;
    @(negedge clk);
    write = 1'b0;
    capture_run(0, 3);
    host_read(3'd0, d); check("unarmed_status", 32'(d), 32'h01);

    // Armed opcode-fetch read cycle
    host_write(3'd0, 8'h02);
    @(negedge clk);
    cpu_ready = 1'b1; cpu_addr = 16'hC123; cpu_d_in = 8'h4C; cpu_d_out = 8'h99;
    cpu_write = 1'b0; sync = 1'b1;
    @(negedge clk);
    cpu_ready = 1'b0; sync = 1'b0;
    check("irq_one", 32'(irq_nonempty), 32'h1);
    host_read(3'd1, d); check("count_one", 32'(d), 32'h01);
    host_read(3'd3, d); check("rd_b0", 32'(d), 32'h23);
    host_read(3'd3, d); check("rd_b1", 32'(d), 32'hC1);
    host_read(3'd3, d); check("rd_b2", 32'(d), 32'h4C);
    host_read(3'd3, d); check("rd_b3", 32'(d), 32'h80);
    host_read(3'd0, d); check("rd_status_after", 32'(d), 32'h01);
    check("irq_zero", 32'(irq_nonempty), 32'h0);

    // CPU write cycle
    @(negedge clk);
    cpu_ready = 1'b1; cpu_addr = 16'h0200; cpu_d_in = 8'h55; cpu_d_out = 8'hAA;
    cpu_write = 1'b1; sync = 1'b0;
    @(negedge clk);
    cpu_ready = 1'b0; cpu_write = 1'b0;
    read_entry(e); check("wr_entry", e, 32'h4002_00AA);

    // Fill past capacity
    capture_run(0, 260);
    host_read(3'd2, d); check("fill_count_hi", 32'(d), 32'h01);
    host_read(3'd1, d); check("fill_count_lo", 32'(d), 32'h00);
    host_read(3'd0, d); check("fill_status", 32'(d), 32'h06);
    check("fill_irq", 32'(irq_nonempty), 32'h1);
    for (int k = 0; k < 256; k++) begin
      read_entry(e);
      check($sformatf("fill_entry_%0d", k), e, exp_entry(k));
    end
    host_read(3'd0, d); check("drain_status_ovf", 32'(d), 32'h05);
    check("drain_irq", 32'(irq_nonempty), 32'h0);

    // Clear keeps armed; then pop coinciding with capture on a full FIFO
    host_write(3'd0, 8'h03);
    host_read(3'd0, d); check("clear_status", 32'(d), 32'h01);
    capture_run(300, 256);
    host_read(3'd0, d); check("full_status", 32'(d), 32'h02);
    host_read(3'd3, d); check("full_b0", 32'(d), 32'(exp_entry(300) & 32'hFF00) >> 8);
    host_read(3'd3, d); check("full_b1", 32'(d), 32'(exp_entry(300) & 32'hFF_0000) >> 16);
    host_read(3'd3, d); check("full_b2", 32'(d), exp_entry(300) & 32'hFF);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 3'd3;
    cpu_ready = 1'b1; cpu_addr = 16'hBEEF; cpu_d_in = 8'h77; cpu_d_out = 8'h11;
    cpu_write = 1'b0; sync = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; cpu_ready = 1'b0; sync = 1'b0;
    check("full_b3", 32'(readdata), exp_entry(300) >> 24);
    host_read(3'd0, d); check("popfull_status", 32'(d), 32'h02);
    host_read(3'd2, d); check("popfull_count_hi", 32'(d), 32'h01);
    host_read(3'd1, d); check("popfull_count_lo", 32'(d), 32'h00);
    for (int k = 301; k < 556; k++) begin
      read_entry(e);
      check($sformatf("popfull_entry_%0d", k), e, exp_entry(k));
    end
    read_entry(e); check("popfull_tail", e, 32'h80BE_EF77);
    host_read(3'd0, d); check("popfull_empty", 32'(d), 32'h01);

    // Clear beats a same-cycle capture
    capture_run(650, 2);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 8'h03;
    drive_cap(652);
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; cpu_ready = 1'b0;
    host_read(3'd1, d); check("clear_vs_cap_count", 32'(d), 32'h00);
    host_read(3'd0, d); check("clear_vs_cap_status", 32'(d), 32'h01);

    // Reset in the middle of draining an entry
    capture_run(600, 2);
    host_read(3'd3, d); check("mid_b0", 32'(d), 32'(exp_entry(600) & 32'hFF00) >> 8);
    host_read(3'd3, d);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_readdata", 32'(readdata), 32'h00);
    check("mid_rst_irq", 32'(irq_nonempty), 32'h0);
    host_read(3'd0, d); check("mid_rst_status", 32'(d), 32'h01);
    capture_run(700, 1);
    host_read(3'd1, d); check("mid_rst_unarmed", 32'(d), 32'h00);
    host_write(3'd0, 8'h02);
    capture_run(602, 1);
    read_entry(e); check("mid_rst_entry", e, exp_entry(602));

    // Unmapped read returns zero; disarm stops capture
    host_read(3'd6, d); check("unmapped_read", 32'(d), 32'h00);
    host_write(3'd0, 8'h00);
    capture_run(800, 4);
    host_read(3'd1, d); check("disarmed_count", 32'(d), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
